// File: rtl/mux_round_robin_arbiter.sv
// Round-robin arbiter that owns the select/enable of a 16:1 mux, one grant at a time.
// Latency: one cycle from a sampled request to a registered grant; re-arbitration happens on the release edge.
// No backpressure: a grant lasts until its request drops, the enable drops, or the hold limit is reached.
module mux_round_robin_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        ClkIn,
  input  logic        RstNIn,
  input  logic        GlobalEnIn,
  input  logic [15:0] ReqIn,
  output logic [3:0]  SelectOut,
  output logic        EnableOut,
  output logic [15:0] GrantOut,
  output logic        BusyOut
);

  typedef enum logic {
    Idle  = 1'b0,
    Grant = 1'b1
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [3:0]  ptr;
  logic [3:0]  ptrNext;
  logic [3:0]  cnt;
  logic [3:0]  cntNext;
  logic [3:0]  selNext;
  logic [15:0] grantNext;
  logic        relNow;
  logic        canGrant;
  logic [3:0]  searchBase;
  logic [4:0]  pick;

  // First set request at or above base, wrapping 15 -> 0; bit 4 flags that one was found.
  // The loop runs from the farthest offset down so the nearest offset is written last and wins.
  function automatic logic [4:0] pickFrom(input logic [15:0] req, input logic [3:0] base);
    logic [3:0] idx;
    pickFrom = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = base + 4'(i);
      if (req[idx]) begin
        pickFrom = {1'b1, idx};
      end
    end
  endfunction

  // A grant is released when its owner stops requesting, the arbiter is disabled, or the hold limit is hit.
  // On release the search starts just past the outgoing owner, so that owner has lowest priority.
  always_comb begin
    relNow     = (state == Grant) &&
                 (!ReqIn[SelectOut] || !GlobalEnIn || (cnt == 4'(HOLD_CYCLES)));
    searchBase = relNow ? 4'(SelectOut + 4'd1) : ptr;
    pick       = pickFrom(ReqIn, searchBase);
    canGrant   = GlobalEnIn && pick[4];
  end

  // Next-state, pointer, counter and registered outputs.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    cntNext   = cnt;
    selNext   = SelectOut;
    grantNext = GrantOut;
    case (state)
      Idle: begin
        cntNext   = 4'd0;
        grantNext = '0;
        if (canGrant) begin
          stateNext = Grant;
          selNext   = pick[3:0];
          cntNext   = 4'd1;
          grantNext = 16'b1 << pick[3:0];
        end
      end
      Grant: begin
        if (relNow) begin
          ptrNext = 4'(SelectOut + 4'd1);
          if (canGrant) begin
            selNext   = pick[3:0];
            cntNext   = 4'd1;
            grantNext = 16'b1 << pick[3:0];
          end else begin
            stateNext = Idle;
            cntNext   = 4'd0;
            grantNext = '0;
          end
        end else begin
          cntNext = 4'(cnt + 4'd1);
        end
      end
      default: begin
        stateNext = Idle;
        cntNext   = 4'd0;
        grantNext = '0;
      end
    endcase
  end

  // State register; reset clears everything without waiting for a clock.
  always_ff @(posedge ClkIn or negedge RstNIn) begin
    if (!RstNIn) begin
      state     <= Idle;
      ptr       <= 4'd0;
      cnt       <= 4'd0;
      SelectOut <= 4'd0;
      GrantOut  <= '0;
    end else begin
      state     <= stateNext;
      ptr       <= ptrNext;
      cnt       <= cntNext;
      SelectOut <= selNext;
      GrantOut  <= grantNext;
    end
  end

  assign EnableOut = (state == Grant);
  assign BusyOut   = (state == Grant);

endmodule

// File: tb/tb_mux_round_robin_arbiter.sv
// Directed bench for the round-robin mux arbiter: vector table plus rotation and async-reset sequences.
// Latency: every vector is applied before a rising edge and checked 1 time unit after it.
// No backpressure on the DUT; all waits are single clock edges of a free-running clock.
module tb_mux_round_robin_arbiter;

  logic        ClkIn;
  logic        RstNIn;
  logic        GlobalEnIn;
  logic [15:0] ReqIn;
  logic [3:0]  SelectOut;
  logic        EnableOut;
  logic [15:0] GrantOut;
  logic        BusyOut;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic [3:0]  sel;
    logic        ena;
    logic [15:0] gnt;
  } vecT;

  vecT vecs[$];

  mux_round_robin_arbiter #(.HOLD_CYCLES(4)) dut (
    .ClkIn      (ClkIn),
    .RstNIn     (RstNIn),
    .GlobalEnIn (GlobalEnIn),
    .ReqIn      (ReqIn),
    .SelectOut  (SelectOut),
    .EnableOut  (EnableOut),
    .GrantOut   (GrantOut),
    .BusyOut    (BusyOut)
  );

  initial ClkIn = 1'b0;
  always #5 ClkIn = ~ClkIn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkOut(input string name, input logic [3:0] sel, input logic ena, input logic [15:0] gnt);
    chk({name, " sel"},   32'(SelectOut), 32'(sel));
    chk({name, " en"},    32'(EnableOut), 32'(ena));
    chk({name, " grant"}, 32'(GrantOut),  32'(gnt));
    chk({name, " busy"},  32'(BusyOut),   32'(ena));
  endtask

  task automatic chkZero(input string name);
    chkOut(name, 4'd0, 1'b0, 16'h0000);
  endtask

  initial begin
    // Single requester 5: four-cycle hold then seamless re-grant, then idle.
    vecs.push_back('{1'b1, 16'h0020, 4'd5,  1'b1, 16'h0020});
    vecs.push_back('{1'b1, 16'h0020, 4'd5,  1'b1, 16'h0020});
    vecs.push_back('{1'b1, 16'h0020, 4'd5,  1'b1, 16'h0020});
    vecs.push_back('{1'b1, 16'h0020, 4'd5,  1'b1, 16'h0020});
    vecs.push_back('{1'b1, 16'h0020, 4'd5,  1'b1, 16'h0020});
    vecs.push_back('{1'b1, 16'h0000, 4'd5,  1'b0, 16'h0000});
    // Grant 3, then 0x8001: search from 4 finds 15, then wraps to 0.
    vecs.push_back('{1'b1, 16'h0008, 4'd3,  1'b1, 16'h0008});
    vecs.push_back('{1'b1, 16'h8001, 4'd15, 1'b1, 16'h8000});
    vecs.push_back('{1'b1, 16'h8001, 4'd15, 1'b1, 16'h8000});
    vecs.push_back('{1'b1, 16'h8001, 4'd15, 1'b1, 16'h8000});
    vecs.push_back('{1'b1, 16'h8001, 4'd15, 1'b1, 16'h8000});
    vecs.push_back('{1'b1, 16'h8001, 4'd0,  1'b1, 16'h0001});
    vecs.push_back('{1'b1, 16'h0000, 4'd0,  1'b0, 16'h0000});
    // Grant 7, drop at Cnt=2 -> idle; next full request shows the pointer moved to 8.
    vecs.push_back('{1'b1, 16'h0080, 4'd7,  1'b1, 16'h0080});
    vecs.push_back('{1'b1, 16'h0080, 4'd7,  1'b1, 16'h0080});
    vecs.push_back('{1'b1, 16'h0000, 4'd7,  1'b0, 16'h0000});
    vecs.push_back('{1'b1, 16'hFFFF, 4'd8,  1'b1, 16'h0100});
    // Grant 2 (search from 9 wraps), disable -> idle, re-enable -> 3.
    vecs.push_back('{1'b1, 16'h0004, 4'd2,  1'b1, 16'h0004});
    vecs.push_back('{1'b0, 16'hFFFF, 4'd2,  1'b0, 16'h0000});
    vecs.push_back('{1'b1, 16'hFFFF, 4'd3,  1'b1, 16'h0008});
    // Non-winner requests change mid-grant: grant on 3 is unaffected.
    vecs.push_back('{1'b1, 16'h0FF8, 4'd3,  1'b1, 16'h0008});
    vecs.push_back('{1'b0, 16'h0000, 4'd3,  1'b0, 16'h0000});
    // Disabled in idle blocks new grants; then enabled resumes from pointer 4.
    vecs.push_back('{1'b0, 16'hFFFF, 4'd3,  1'b0, 16'h0000});
    vecs.push_back('{1'b1, 16'h0010, 4'd4,  1'b1, 16'h0010});

    RstNIn     = 1'b0;
    GlobalEnIn = 1'b0;
    ReqIn      = 16'h0000;
    #2;
    chkZero("reset");
    #10;
    RstNIn = 1'b1;

    // Table: drive inputs between edges, check just after the edge.
    for (int i = 0; i < vecs.size(); i++) begin
      GlobalEnIn = vecs[i].en;
      ReqIn      = vecs[i].req;
      @(posedge ClkIn);
      #1;
      chkOut($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ena, vecs[i].gnt);
    end

    // Reset mid-grant, between edges: outputs clear without a clock.
    RstNIn = 1'b0;
    #1;
    chkZero("async reset mid-grant");
    #1;
    RstNIn = 1'b1;

    // All requesting: 0..15 then 0 again, each owning the mux for 4 cycles.
    GlobalEnIn = 1'b1;
    ReqIn      = 16'hFFFF;
    for (int w = 0; w <= 16; w++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge ClkIn);
        #1;
        chkOut($sformatf("rot w%0d c%0d", w, c), 4'(w), 1'b1, 16'b1 << (w % 16));
      end
    end

    // Pulse reset between edges, then request 1 and 2: restart from pointer 0 grants 1.
    #2;
    RstNIn = 1'b0;
    #1;
    chkZero("reset pulse");
    ReqIn = 16'h0006;
    #1;
    RstNIn = 1'b1;
    @(posedge ClkIn);
    #1;
    chkOut("post-reset grant", 4'd1, 1'b1, 16'h0002);
    @(posedge ClkIn);
    #1;
    chkOut("post-reset hold", 4'd1, 1'b1, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
